// File: rtl/gear_pkg.sv
// Shared definitions for the gear shift controller and its neighbours.
// Holds the sequencer state encoding, the gear range limits, the per-gear
// over-rev speed ceiling table and small gear helper functions.
package gear_pkg;

    // Shift sequencer states
    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        CLUTCH_IN  = 2'd1,
        SHIFT      = 2'd2,
        CLUTCH_OUT = 2'd3
    } gear_state_e;

    localparam logic [2:0] GEAR_NEUTRAL = 3'd0;
    localparam logic [2:0] GEAR_MAX     = 3'd6;

    // Highest speed at which the given gear may be engaged by a downshift.
    // Neutral has no ceiling.
    function automatic logic [7:0] max_speed(input logic [2:0] gear);
        logic [7:0] limit;
        case (gear)
            3'd1:    limit = 8'd30;
            3'd2:    limit = 8'd50;
            3'd3:    limit = 8'd80;
            3'd4:    limit = 8'd110;
            3'd5:    limit = 8'd150;
            3'd6:    limit = 8'd255;
            default: limit = 8'd255;
        endcase
        return limit;
    endfunction

    // Requests above the top gear are treated as the top gear.
    function automatic logic [2:0] clamp_gear(input logic [2:0] gear);
        logic [2:0] clamped;
        if (gear > GEAR_MAX) begin
            clamped = GEAR_MAX;
        end else begin
            clamped = gear;
        end
        return clamped;
    endfunction

endpackage

// File: rtl/gear_dwell_timer.sv
// Loadable down-counter used to time the dwell in each shift phase.
// Loading N gives N+1 cycles until done (done is high while the count is 0),
// so the sequencer loads (cycles - 1) on each state change.
module gear_dwell_timer #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             done
);

    logic [CNT_W-1:0] cnt_r;

    // Count register: synchronous clear, reload on request, else count down to zero and hold
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (load) begin
            cnt_r <= load_val;
        end else if (cnt_r != {CNT_W{1'b0}}) begin
            cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign done = (cnt_r == {CNT_W{1'b0}});

endmodule

// File: rtl/gear_shift_controller.sv
// Gear shift sequencer: walks the engaged gear one step at a time toward the
// requested gear, each step running clutch-in, shift and clutch-out dwells.
// Optional feature macro: OVERREV_GUARD_EN -- when defined, a downshift into
// gear 1..5 is refused while speed exceeds that gear's ceiling.
module gear_shift_controller
    import gear_pkg::*;
#(
    parameter int CLUTCH_CYCLES = 4,
    parameter int SHIFT_CYCLES  = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] target_gear,
    input  logic [7:0] speed,
    output logic [2:0] cur_gear,
    output logic       clutch,
    output logic       shifting,
    output logic       shift_dir,
    output logic       shift_done,
    output logic       shift_blocked
);

    localparam int MAX_DWELL = (CLUTCH_CYCLES > SHIFT_CYCLES) ? CLUTCH_CYCLES : SHIFT_CYCLES;
    localparam int CNT_W     = (MAX_DWELL > 1) ? $clog2(MAX_DWELL) : 1;
    localparam logic [CNT_W-1:0] CLUTCH_LOAD = CNT_W'(CLUTCH_CYCLES - 1);
    localparam logic [CNT_W-1:0] SHIFT_LOAD  = CNT_W'(SHIFT_CYCLES - 1);

    gear_state_e      state_r;
    gear_state_e      next_state_s;
    logic [2:0]       cur_gear_r;
    logic [2:0]       next_gear_s;
    logic             dir_r;
    logic             next_dir_s;
    logic             clutch_r;
    logic             shifting_r;
    logic             shift_done_r;
    logic [2:0]       target_s;
    logic             guard_ok_s;
    logic             blocked_s;
    logic             load_s;
    logic [CNT_W-1:0] load_val_s;
    logic             dwell_done_s;

    assign target_s = clamp_gear(target_gear);

`ifdef OVERREV_GUARD_EN
    // Over-rev guard: a downshift into a driving gear needs speed within that gear's ceiling
    always_comb begin
        guard_ok_s = 1'b1;
        if (cur_gear_r >= 3'd2) begin
            guard_ok_s = (speed <= max_speed(cur_gear_r - 3'd1));
        end else begin
            guard_ok_s = 1'b1;
        end
    end
`else
    logic unused_speed_s;
    assign unused_speed_s = ^speed;

    // No guard: every downshift is allowed
    always_comb begin
        guard_ok_s = 1'b1;
    end
`endif

    // Next-state, next-gear and direction decisions for the shift sequence
    always_comb begin
        next_state_s = state_r;
        next_gear_s  = cur_gear_r;
        next_dir_s   = dir_r;
        load_val_s   = CLUTCH_LOAD;
        blocked_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (target_s > cur_gear_r) begin
                    next_dir_s   = 1'b1;
                    next_state_s = CLUTCH_IN;
                end else if (target_s < cur_gear_r) begin
                    if (guard_ok_s) begin
                        next_dir_s   = 1'b0;
                        next_state_s = CLUTCH_IN;
                    end else begin
                        blocked_s    = 1'b1;
                    end
                end else begin
                    next_state_s = IDLE;
                end
            end
            CLUTCH_IN: begin
                if (dwell_done_s) begin
                    next_state_s = SHIFT;
                    load_val_s   = SHIFT_LOAD;
                end else begin
                    next_state_s = CLUTCH_IN;
                end
            end
            SHIFT: begin
                if (dwell_done_s) begin
                    // Direction was checked against the bounds in IDLE, so no wrap can occur
                    if (dir_r) begin
                        next_gear_s = cur_gear_r + 3'd1;
                    end else begin
                        next_gear_s = cur_gear_r - 3'd1;
                    end
                    next_state_s = CLUTCH_OUT;
                    load_val_s   = CLUTCH_LOAD;
                end else begin
                    next_state_s = SHIFT;
                end
            end
            CLUTCH_OUT: begin
                if (dwell_done_s) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = CLUTCH_OUT;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // The dwell counter restarts whenever the state changes
    assign load_s = (next_state_s != state_r);

    gear_dwell_timer #(
        .CNT_W (CNT_W)
    ) u_dwell (
        .clk      (clk),
        .rst      (rst),
        .load     (load_s),
        .load_val (load_val_s),
        .done     (dwell_done_s)
    );

    // State, gear and registered status outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r      <= IDLE;
            cur_gear_r   <= GEAR_NEUTRAL;
            dir_r        <= 1'b0;
            clutch_r     <= 1'b0;
            shifting_r   <= 1'b0;
            shift_done_r <= 1'b0;
        end else begin
            state_r      <= next_state_s;
            cur_gear_r   <= next_gear_s;
            dir_r        <= next_dir_s;
            clutch_r     <= (next_state_s != IDLE);
            shifting_r   <= (next_state_s != IDLE);
            shift_done_r <= (state_r == CLUTCH_OUT) && (next_state_s == IDLE);
        end
    end

    assign cur_gear      = cur_gear_r;
    assign clutch        = clutch_r;
    assign shifting      = shifting_r;
    assign shift_dir     = dir_r;
    assign shift_done    = shift_done_r;
    // Refusal is reported in the same IDLE cycle in which it happens
    assign shift_blocked = blocked_s;

endmodule

// File: tb/tb_gear_shift_controller.sv
// Bench for gear_shift_controller: directed stimulus pushes the expected
// completion of each gear step (gear, direction, cycle) into a scoreboard;
// a monitor pops and checks on every shift_done pulse.
module tb_gear_shift_controller;

    logic       clk;
    logic       rst;
    logic [2:0] target_gear;
    logic [7:0] speed;
    logic [2:0] cur_gear;
    logic       clutch;
    logic       shifting;
    logic       shift_dir;
    logic       shift_done;
    logic       shift_blocked;

    typedef struct {
        logic [2:0] gear;
        logic       dir;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc;
    int   tests;
    int   fails;
    logic last_dir;

    gear_shift_controller #(
        .CLUTCH_CYCLES (4),
        .SHIFT_CYCLES  (8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .target_gear   (target_gear),
        .speed         (speed),
        .cur_gear      (cur_gear),
        .clutch        (clutch),
        .shifting      (shifting),
        .shift_dir     (shift_dir),
        .shift_done    (shift_done),
        .shift_blocked (shift_blocked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic at_cycle(input int c);
        @(negedge clk);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic expect_step(input int g, input int d, input int c);
        exp_t e;
        e.gear = 3'(g);
        e.dir  = d[0];
        e.cyc  = c;
        sb.push_back(e);
    endtask

    // Monitor: remember direction while shifting, check each completed step
    always @(negedge clk) begin
        if (rst && shifting) last_dir = shift_dir;
        if (rst && shift_done) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: got pulse at cycle %0d expected none", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("done_gear", int'(cur_gear), int'(e.gear));
                chk("done_dir", int'(last_dir), int'(e.dir));
                chk("done_cycle", cyc, e.cyc);
            end
        end
    end

    // Watchdog so the run always ends
    initial begin
        #50000;
        $display("FAIL watchdog: got no finish expected finish by cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int n, p, q, r, s, t, u, v;
        cyc = 0; tests = 0; fails = 0; last_dir = 1'b0;
        rst = 1'b0; target_gear = 3'd0; speed = 8'd0;

        // Reset values
        at_cycle(2);
        chk("rst_gear", cur_gear, 0);
        chk("rst_clutch", clutch, 0);
        chk("rst_shifting", shifting, 0);
        chk("rst_dir", shift_dir, 0);
        chk("rst_done", shift_done, 0);
        chk("rst_blocked", shift_blocked, 0);
        rst = 1'b1;

        // Target neutral: nothing happens
        for (int i = 0; i < 20; i++) begin
            at_cycle(cyc + 1);
            chk("idle_shifting", shifting, 0);
            chk("idle_gear", cur_gear, 0);
        end

        // Single upshift 0->1 timing
        at_cycle(cyc + 1);
        n = cyc;
        target_gear = 3'd1;
        expect_step(1, 1, n + 17);
        at_cycle(n + 1);
        chk("t01_clutch_n1", clutch, 1);
        chk("t01_shifting_n1", shifting, 1);
        at_cycle(n + 12);
        chk("t01_gear_n12", cur_gear, 0);
        at_cycle(n + 13);
        chk("t01_gear_n13", cur_gear, 1);
        chk("t01_clutch_n13", clutch, 1);
        at_cycle(n + 17);
        chk("t01_clutch_n17", clutch, 0);

        // Reset asserted during SHIFT
        at_cycle(n + 18);
        p = cyc;
        target_gear = 3'd2;
        at_cycle(p + 7);
        chk("mid_shifting", shifting, 1);
        rst = 1'b0;
        target_gear = 3'd0;
        at_cycle(p + 8);
        chk("mid_rst_gear", cur_gear, 0);
        chk("mid_rst_clutch", clutch, 0);
        chk("mid_rst_shifting", shifting, 0);
        chk("mid_rst_dir", shift_dir, 0);
        chk("mid_rst_done", shift_done, 0);
        chk("mid_rst_blocked", shift_blocked, 0);
        rst = 1'b1;
        at_cycle(p + 10);
        chk("mid_after_shifting", shifting, 0);

        // Multi-step 0->3
        at_cycle(p + 11);
        q = cyc;
        target_gear = 3'd3;
        expect_step(1, 1, q + 17);
        expect_step(2, 1, q + 34);
        expect_step(3, 1, q + 51);
        at_cycle(q + 30);
        chk("t03_dir_mid", shift_dir, 1);
        at_cycle(q + 52);
        chk("t03_gear", cur_gear, 3);
        chk("t03_idle", shifting, 0);

        // Target reversal during CLUTCH_IN: 3->4 then 4->2
        r = cyc;
        target_gear = 3'd4;
        at_cycle(r + 2);
        target_gear = 3'd2;
        expect_step(4, 1, r + 17);
        expect_step(3, 0, r + 34);
        expect_step(2, 0, r + 51);
        at_cycle(r + 52);
        chk("rev_gear", cur_gear, 2);
        chk("rev_idle", shifting, 0);

        // Climb to gear 4 for the guard check
        s = cyc;
        target_gear = 3'd4;
        expect_step(3, 1, s + 17);
        expect_step(4, 1, s + 34);
        at_cycle(s + 35);
        chk("g4_gear", cur_gear, 4);
        t = cyc;
        speed = 8'd100;
        target_gear = 3'd3;
        #1;
`ifdef OVERREV_GUARD_EN
        chk("guard_blocked_now", shift_blocked, 1);
        at_cycle(t + 1);
        chk("guard_blocked_hold", shift_blocked, 1);
        chk("guard_no_shift", shifting, 0);
        chk("guard_gear_kept", cur_gear, 4);
        at_cycle(t + 3);
        u = cyc;
        speed = 8'd80;
        #1;
        chk("guard_released", shift_blocked, 0);
        expect_step(3, 0, u + 17);
        at_cycle(u + 1);
        chk("guard_clutch", clutch, 1);
        at_cycle(u + 13);
        chk("guard_gear3", cur_gear, 3);
        at_cycle(u + 17);
        v = cyc;
`else
        chk("noguard_blocked", shift_blocked, 0);
        expect_step(3, 0, t + 17);
        at_cycle(t + 1);
        chk("noguard_shifting", shifting, 1);
        chk("noguard_blocked_n1", shift_blocked, 0);
        at_cycle(t + 13);
        chk("noguard_gear3", cur_gear, 3);
        at_cycle(t + 17);
        v = cyc;
`endif

        // Target 7 is treated as 6
        speed = 8'd0;
        at_cycle(v + 1);
        target_gear = 3'd7;
        expect_step(4, 1, v + 18);
        expect_step(5, 1, v + 35);
        expect_step(6, 1, v + 52);
        at_cycle(v + 53);
        chk("clamp_gear", cur_gear, 6);
        at_cycle(v + 60);
        chk("clamp_idle", shifting, 0);
        chk("clamp_gear_hold", cur_gear, 6);

        at_cycle(cyc + 3);
        chk("sb_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
